// File: rtl/mc_cu.sv
// mc_cu: multi-cycle MIPS control FSM with memory wait watchdog and retired counter
module mc_cu #(
    parameter bit MEM_HS   = 1'b1,
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             z,
    input  logic             mem_ready,
    output logic             wpc,
    output logic             wir,
    output logic             wmem,
    output logic             wreg,
    output logic             iord,
    output logic             regrt,
    output logic             m2reg,
    output logic             jal,
    output logic             sext,
    output logic             shift,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [3:0]       aluc,
    output logic [1:0]       pcsource,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             err,
    output logic             illegal
);
    localparam int WW = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd5
    } state_t;

    state_t st, nst;
    logic [WW-1:0] wcnt;
    logic wpc_c, wir_c, wmem_c, wreg_c;
    logic rdy, wd, r;
    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
    logic i_imm, legal;

    assign r      = op == 6'b000000;
    assign i_add  = r & (func == 6'b100000);
    assign i_sub  = r & (func == 6'b100010);
    assign i_and  = r & (func == 6'b100100);
    assign i_or   = r & (func == 6'b100101);
    assign i_xor  = r & (func == 6'b100110);
    assign i_sll  = r & (func == 6'b000000);
    assign i_srl  = r & (func == 6'b000010);
    assign i_sra  = r & (func == 6'b000011);
    assign i_jr   = r & (func == 6'b001000);
    assign i_addi = op == 6'b001000;
    assign i_andi = op == 6'b001100;
    assign i_ori  = op == 6'b001101;
    assign i_xori = op == 6'b001110;
    assign i_lui  = op == 6'b001111;
    assign i_lw   = op == 6'b100011;
    assign i_sw   = op == 6'b101011;
    assign i_beq  = op == 6'b000100;
    assign i_bne  = op == 6'b000101;
    assign i_j    = op == 6'b000010;
    assign i_jal  = op == 6'b000011;
    assign i_imm  = i_addi | i_andi | i_ori | i_xori | i_lui;
    assign legal  = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra | i_jr |
                    i_imm | i_lw | i_sw | i_beq | i_bne | i_j | i_jal;

    // without the handshake memory always completes in one cycle
    assign rdy = !MEM_HS || mem_ready;
    assign wd  = MEM_HS && !mem_ready && (wcnt == WW'(WAIT_MAX - 1));

    // write enables are killed while reset is held, even mid-instruction
    assign wpc   = wpc_c & resetn;
    assign wir   = wir_c & resetn;
    assign wmem  = wmem_c & resetn;
    assign wreg  = wreg_c & resetn;
    assign state = st;

    // per-state datapath controls and next-state selection
    always_comb begin
        nst = st;
        {wpc_c, wir_c, wmem_c, wreg_c} = 4'b0000;
        {iord, regrt, m2reg, jal, sext, shift, alusrca, illegal} = 8'b0;
        alusrcb  = 2'b00;
        aluc     = 4'b0000;
        pcsource = 2'b00;
        case (st)
            S_IF: begin
                alusrcb = 2'b01;
                wpc_c   = rdy;
                wir_c   = rdy;
                nst     = rdy ? S_ID : wd ? S_ERR : S_IF;
            end
            S_ID: begin
                alusrcb  = 2'b11;
                sext     = 1'b1;
                wpc_c    = i_j | i_jal | i_jr;
                wreg_c   = i_jal;
                jal      = i_jal;
                pcsource = (i_j | i_jal) ? 2'b11 : i_jr ? 2'b10 : 2'b00;
                illegal  = !legal;
                nst      = (i_j | i_jal | i_jr | !legal) ? S_IF : S_EXE;
            end
            S_EXE: begin
                alusrca  = 1'b1;
                shift    = i_sll | i_srl | i_sra;
                alusrcb  = (i_imm | i_lw | i_sw) ? 2'b10 : 2'b00;
                sext     = i_addi | i_lw | i_sw | i_beq | i_bne;
                aluc     = (i_sub | i_beq | i_bne) ? 4'b0100 :
                           (i_and | i_andi)        ? 4'b0001 :
                           (i_or  | i_ori)         ? 4'b0101 :
                           (i_xor | i_xori)        ? 4'b0010 :
                           i_lui                   ? 4'b0110 :
                           i_sll                   ? 4'b0011 :
                           i_srl                   ? 4'b0111 :
                           i_sra                   ? 4'b1111 : 4'b0000;
                pcsource = (i_beq | i_bne) ? 2'b01 : 2'b00;
                wpc_c    = (i_beq & z) | (i_bne & ~z);
                nst      = (i_beq | i_bne) ? S_IF : (i_lw | i_sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                iord   = 1'b1;
                wmem_c = i_sw;
                nst    = rdy ? (i_sw ? S_IF : S_WB) : wd ? S_ERR : S_MEM;
            end
            S_WB: begin
                wreg_c = 1'b1;
                regrt  = i_imm | i_lw;
                m2reg  = i_lw;
                nst    = S_IF;
            end
            S_ERR: nst = S_ERR;
            default: nst = S_IF;
        endcase
    end

    // state, sticky error, wait watchdog and retired-instruction counter
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            st      <= S_IF;
            wcnt    <= '0;
            err     <= 1'b0;
            retired <= '0;
        end else begin
            st      <= nst;
            err     <= err | (nst == S_ERR);
            wcnt    <= (nst != st) ? '0 :
                       (MEM_HS && !mem_ready && (st == S_IF || st == S_MEM)) ? wcnt + WW'(1) : wcnt;
            retired <= retired + CNT_W'(nst == S_IF && st != S_IF && st != S_ERR);
        end
    end
endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu: scoreboard bench for mc_cu, handshake/small-counter and single-cycle-memory variants
module tb_mc_cu;
    logic clock = 1'b0;
    logic resetn = 1'b0, resetn_b = 1'b0;
    logic [5:0] op = '0, func = '0;
    logic z = 1'b0, mem_ready = 1'b1;

    logic wpc_a, wir_a, wmem_a, wreg_a, iord_a, regrt_a, m2reg_a, jal_a, sext_a, shift_a, alusrca_a, err_a, ill_a;
    logic [1:0] alusrcb_a, pcsource_a, ret_a;
    logic [3:0] aluc_a;
    logic [2:0] st_a;
    logic wpc_b, wir_b, wmem_b, wreg_b, iord_b, regrt_b, m2reg_b, jal_b, sext_b, shift_b, alusrca_b, err_b, ill_b;
    logic [1:0] alusrcb_b, pcsource_b;
    logic [15:0] ret_b;
    logic [3:0] aluc_b;
    logic [2:0] st_b;

    mc_cu #(.MEM_HS(1'b1), .WAIT_MAX(4), .CNT_W(2)) dut_a (
        .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
        .wpc(wpc_a), .wir(wir_a), .wmem(wmem_a), .wreg(wreg_a), .iord(iord_a), .regrt(regrt_a),
        .m2reg(m2reg_a), .jal(jal_a), .sext(sext_a), .shift(shift_a), .alusrca(alusrca_a),
        .alusrcb(alusrcb_a), .aluc(aluc_a), .pcsource(pcsource_a), .state(st_a),
        .retired(ret_a), .err(err_a), .illegal(ill_a)
    );

    mc_cu #(.MEM_HS(1'b0), .WAIT_MAX(16), .CNT_W(16)) dut_b (
        .clock(clock), .resetn(resetn_b), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
        .wpc(wpc_b), .wir(wir_b), .wmem(wmem_b), .wreg(wreg_b), .iord(iord_b), .regrt(regrt_b),
        .m2reg(m2reg_b), .jal(jal_b), .sext(sext_b), .shift(shift_b), .alusrca(alusrca_b),
        .alusrcb(alusrcb_b), .aluc(aluc_b), .pcsource(pcsource_b), .state(st_b),
        .retired(ret_b), .err(err_b), .illegal(ill_b)
    );

    always #5 clock = ~clock;

    // mux word layout: iord regrt m2reg jal sext shift alusrca alusrcb[1:0] aluc[3:0] pcsource[1:0]
    function automatic logic [14:0] m(input logic io, rt, m2, jl, sx, sh, sa,
                                      input logic [1:0] b, input logic [3:0] c, input logic [1:0] p);
        return {io, rt, m2, jl, sx, sh, sa, b, c, p};
    endfunction

    localparam logic [5:0] R = 6'b000000;
    localparam logic [5:0] F_ADD = 6'b100000, F_SLL = 6'b000000, F_JR = 6'b001000;
    localparam logic [5:0] O_LW = 6'b100011, O_SW = 6'b101011, O_BEQ = 6'b000100, O_BNE = 6'b000101;
    localparam logic [5:0] O_J = 6'b000010, O_JAL = 6'b000011, O_ORI = 6'b001101, O_BAD = 6'b111111;

    logic [14:0] m_if, m_id, m_id_j, m_id_jal, m_id_jr, m_exe_r, m_exe_mem, m_exe_br, m_exe_ori, m_exe_sll;
    logic [14:0] m_mem, m_wb_r, m_wb_i, m_wb_lw, m_none;

    typedef struct {
        bit          dut;
        logic [2:0]  st;
        logic [3:0]  en;
        logic [15:0] ret;
        logic        er;
        logic        il;
        logic [14:0] mux;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0, passed = 0;
    logic [39:0] act, want;
    logic [14:0] mux_a, mux_b;

    assign mux_a = {iord_a, regrt_a, m2reg_a, jal_a, sext_a, shift_a, alusrca_a, alusrcb_a, aluc_a, pcsource_a};
    assign mux_b = {iord_b, regrt_b, m2reg_b, jal_b, sext_b, shift_b, alusrca_b, alusrcb_b, aluc_b, pcsource_b};

    // monitor: one expected entry per cycle, compared on the falling edge
    always @(negedge clock) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            act = e.dut ? {st_b, wpc_b, wir_b, wmem_b, wreg_b, ret_b, err_b, ill_b, mux_b}
                        : {st_a, wpc_a, wir_a, wmem_a, wreg_a, 14'b0, ret_a, err_a, ill_a, mux_a};
            want = {e.st, e.en, e.ret, e.er, e.il, e.mux};
            checks++;
            if (act === want) passed++;
            else $display("FAIL %s: got st=%0d en=%b ret=%0d err=%b ill=%b mux=%b, want st=%0d en=%b ret=%0d err=%b ill=%b mux=%b",
                          e.name, act[39:37], act[36:33], act[32:17], act[16], act[15], act[14:0],
                          want[39:37], want[36:33], want[32:17], want[16], want[15], want[14:0]);
        end
    end

    // drive one cycle of inputs and queue the hand-computed response; en = {wpc,wir,wmem,wreg}
    task automatic cyc(input bit d, input logic rn, input logic [5:0] o, input logic [5:0] f,
                       input logic zz, input logic rr, input logic [2:0] s, input logic [3:0] en,
                       input int ret, input logic er, input logic il, input logic [14:0] mx, input string nm);
        exp_t x;
        @(posedge clock);
        #1;
        if (d) resetn_b = rn; else resetn = rn;
        op = o; func = f; z = zz; mem_ready = rr;
        x.dut = d; x.st = s; x.en = en; x.ret = 16'(ret); x.er = er; x.il = il; x.mux = mx; x.name = nm;
        q.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        m_if      = m(0,0,0,0,0,0,0,2'b01,4'b0000,2'b00);
        m_id      = m(0,0,0,0,1,0,0,2'b11,4'b0000,2'b00);
        m_id_j    = m(0,0,0,0,1,0,0,2'b11,4'b0000,2'b11);
        m_id_jal  = m(0,0,0,1,1,0,0,2'b11,4'b0000,2'b11);
        m_id_jr   = m(0,0,0,0,1,0,0,2'b11,4'b0000,2'b10);
        m_exe_r   = m(0,0,0,0,0,0,1,2'b00,4'b0000,2'b00);
        m_exe_mem = m(0,0,0,0,1,0,1,2'b10,4'b0000,2'b00);
        m_exe_br  = m(0,0,0,0,1,0,1,2'b00,4'b0100,2'b01);
        m_exe_ori = m(0,0,0,0,0,0,1,2'b10,4'b0101,2'b00);
        m_exe_sll = m(0,0,0,0,0,1,1,2'b00,4'b0011,2'b00);
        m_mem     = m(1,0,0,0,0,0,0,2'b00,4'b0000,2'b00);
        m_wb_r    = m(0,0,0,0,0,0,0,2'b00,4'b0000,2'b00);
        m_wb_i    = m(0,1,0,0,0,0,0,2'b00,4'b0000,2'b00);
        m_wb_lw   = m(0,1,1,0,0,0,0,2'b00,4'b0000,2'b00);
        m_none    = '0;

        cyc(0,0,R,F_ADD,0,1, 0,4'b0000,0,0,0,m_if,"reset");
        // add: IF ID EXE WB
        cyc(0,1,R,F_ADD,0,1, 0,4'b1100,0,0,0,m_if,"add_if");
        cyc(0,1,R,F_ADD,0,1, 1,4'b0000,0,0,0,m_id,"add_id");
        cyc(0,1,R,F_ADD,0,1, 2,4'b0000,0,0,0,m_exe_r,"add_exe");
        cyc(0,1,R,F_ADD,0,1, 4,4'b0001,0,0,0,m_wb_r,"add_wb");
        // lw with three wait cycles in MEM
        cyc(0,1,O_LW,0,0,1, 0,4'b1100,1,0,0,m_if,"lw_if");
        cyc(0,1,O_LW,0,0,1, 1,4'b0000,1,0,0,m_id,"lw_id");
        cyc(0,1,O_LW,0,0,1, 2,4'b0000,1,0,0,m_exe_mem,"lw_exe");
        for (int i = 0; i < 3; i++) cyc(0,1,O_LW,0,0,0, 3,4'b0000,1,0,0,m_mem,"lw_mem_wait");
        cyc(0,1,O_LW,0,0,1, 3,4'b0000,1,0,0,m_mem,"lw_mem_rdy");
        cyc(0,1,O_LW,0,0,1, 4,4'b0001,1,0,0,m_wb_lw,"lw_wb");
        // branches
        cyc(0,1,O_BEQ,0,1,1, 0,4'b1100,2,0,0,m_if,"beq1_if");
        cyc(0,1,O_BEQ,0,1,1, 1,4'b0000,2,0,0,m_id,"beq1_id");
        cyc(0,1,O_BEQ,0,1,1, 2,4'b1000,2,0,0,m_exe_br,"beq_z1_exe");
        cyc(0,1,O_BEQ,0,0,1, 0,4'b1100,3,0,0,m_if,"beq0_if");
        cyc(0,1,O_BEQ,0,0,1, 1,4'b0000,3,0,0,m_id,"beq0_id");
        cyc(0,1,O_BEQ,0,0,1, 2,4'b0000,3,0,0,m_exe_br,"beq_z0_exe");
        cyc(0,1,O_BNE,0,0,1, 0,4'b1100,0,0,0,m_if,"bne0_if_wrap");
        cyc(0,1,O_BNE,0,0,1, 1,4'b0000,0,0,0,m_id,"bne0_id");
        cyc(0,1,O_BNE,0,0,1, 2,4'b1000,0,0,0,m_exe_br,"bne_z0_exe");
        cyc(0,1,O_BNE,0,1,1, 0,4'b1100,1,0,0,m_if,"bne1_if");
        cyc(0,1,O_BNE,0,1,1, 1,4'b0000,1,0,0,m_id,"bne1_id");
        cyc(0,1,O_BNE,0,1,1, 2,4'b0000,1,0,0,m_exe_br,"bne_z1_exe");
        // illegal opcode and jumps resolve in ID
        cyc(0,1,O_BAD,0,0,1, 0,4'b1100,2,0,0,m_if,"bad_if");
        cyc(0,1,O_BAD,0,0,1, 1,4'b0000,2,0,1,m_id,"bad_id");
        cyc(0,1,O_J,0,0,1, 0,4'b1100,3,0,0,m_if,"j_if");
        cyc(0,1,O_J,0,0,1, 1,4'b1000,3,0,0,m_id_j,"j_id");
        cyc(0,1,O_JAL,0,0,1, 0,4'b1100,0,0,0,m_if,"jal_if");
        cyc(0,1,O_JAL,0,0,1, 1,4'b1001,0,0,0,m_id_jal,"jal_id");
        cyc(0,1,R,F_JR,0,1, 0,4'b1100,1,0,0,m_if,"jr_if");
        cyc(0,1,R,F_JR,0,1, 1,4'b1000,1,0,0,m_id_jr,"jr_id");
        // sw with one wait cycle
        cyc(0,1,O_SW,0,0,1, 0,4'b1100,2,0,0,m_if,"sw_if");
        cyc(0,1,O_SW,0,0,1, 1,4'b0000,2,0,0,m_id,"sw_id");
        cyc(0,1,O_SW,0,0,1, 2,4'b0000,2,0,0,m_exe_mem,"sw_exe");
        cyc(0,1,O_SW,0,0,0, 3,4'b0010,2,0,0,m_mem,"sw_mem_wait");
        cyc(0,1,O_SW,0,0,1, 3,4'b0010,2,0,0,m_mem,"sw_mem_rdy");
        // ori and sll
        cyc(0,1,O_ORI,0,0,1, 0,4'b1100,3,0,0,m_if,"ori_if");
        cyc(0,1,O_ORI,0,0,1, 1,4'b0000,3,0,0,m_id,"ori_id");
        cyc(0,1,O_ORI,0,0,1, 2,4'b0000,3,0,0,m_exe_ori,"ori_exe");
        cyc(0,1,O_ORI,0,0,1, 4,4'b0001,3,0,0,m_wb_i,"ori_wb");
        cyc(0,1,R,F_SLL,0,1, 0,4'b1100,0,0,0,m_if,"sll_if");
        cyc(0,1,R,F_SLL,0,1, 1,4'b0000,0,0,0,m_id,"sll_id");
        cyc(0,1,R,F_SLL,0,1, 2,4'b0000,0,0,0,m_exe_sll,"sll_exe");
        cyc(0,1,R,F_SLL,0,1, 4,4'b0001,0,0,0,m_wb_r,"sll_wb");
        // watchdog: four stalled fetch cycles lead to a sticky ERR
        for (int i = 0; i < 4; i++) cyc(0,1,R,F_ADD,0,0, 0,4'b0000,1,0,0,m_if,"wd_if_wait");
        cyc(0,1,R,F_ADD,0,1, 5,4'b0000,1,1,0,m_none,"wd_err");
        cyc(0,1,R,F_ADD,0,1, 5,4'b0000,1,1,0,m_none,"wd_err_sticky");
        cyc(0,0,R,F_ADD,0,1, 0,4'b0000,0,0,0,m_if,"wd_reset");
        // ready on the final allowed cycle wins
        for (int i = 0; i < 3; i++) cyc(0,1,O_BAD,0,0,0, 0,4'b0000,0,0,0,m_if,"last_if_wait");
        cyc(0,1,O_BAD,0,0,1, 0,4'b1100,0,0,0,m_if,"last_if_rdy");
        cyc(0,1,O_BAD,0,0,1, 1,4'b0000,0,0,1,m_id,"last_id");
        cyc(0,1,O_BAD,0,0,1, 0,4'b1100,1,0,0,m_if,"last_back_if");
        // reset asserted during sw MEM
        cyc(0,1,O_SW,0,0,1, 1,4'b0000,1,0,0,m_id,"swr_id");
        cyc(0,1,O_SW,0,0,1, 2,4'b0000,1,0,0,m_exe_mem,"swr_exe");
        cyc(0,1,O_SW,0,0,0, 3,4'b0010,1,0,0,m_mem,"swr_mem");
        cyc(0,0,O_SW,0,0,0, 0,4'b0000,0,0,0,m_if,"swr_reset");
        // single-cycle memory variant: lw ignores mem_ready
        cyc(1,0,O_LW,0,0,0, 0,4'b0000,0,0,0,m_if,"b_reset");
        cyc(1,1,O_LW,0,0,0, 0,4'b1100,0,0,0,m_if,"b_lw_if");
        cyc(1,1,O_LW,0,0,0, 1,4'b0000,0,0,0,m_id,"b_lw_id");
        cyc(1,1,O_LW,0,0,0, 2,4'b0000,0,0,0,m_exe_mem,"b_lw_exe");
        cyc(1,1,O_LW,0,0,0, 3,4'b0000,0,0,0,m_mem,"b_lw_mem");
        cyc(1,1,O_LW,0,0,0, 4,4'b0001,0,0,0,m_wb_lw,"b_lw_wb");
        cyc(1,1,O_LW,0,0,0, 0,4'b1100,1,0,0,m_if,"b_lw_done");

        repeat (3) @(negedge clock);
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/mc_cu.md
Name: mc_cu

Overview:
- Multi-cycle MIPS control unit: a registered FSM that sequences IF/ID/EXE/MEM/WB over a shared-ALU, shared-memory datapath.
- Covers the same instruction subset as the single-cycle CPU.
- Adds a parametrised memory ready-handshake with a wait watchdog, a retired-instruction counter and illegal-opcode reporting.

Parameters:
MEM_HS, 1, 1: IF/MEM wait for mem_ready; 0: memory is single-cycle and mem_ready is ignored (treated as 1)
WAIT_MAX, 16, max consecutive wait cycles in IF or MEM before the error state (MEM_HS=1 only); must be ≥1
CNT_W, 16, width of the retired-instruction counter

Ports:
clock  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
op  in  6  instruction [31:26] from IR
func  in  6  instruction [5:0] from IR
z  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
wpc, wir, wmem, wreg  out  1 each  PC, IR, memory and register-file write enables
iord  out  1  memory address select: 0=PC, 1=ALU result register
regrt  out  1  destination register select: 1=rt, 0=rd
m2reg  out  1  write-back source: 1=memory data
jal  out  1  force destination r31 and write PC
sext  out  1  sign-extend imm16
shift  out  1  ALU A operand = sa
alusrca  out  1  ALU A operand: 0=PC, 1=reg/sa
alusrcb  out  2  ALU B operand: 00=reg, 01=const 4, 10=ext imm, 11=ext imm<<2
aluc  out  4  ALU op: add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111
pcsource  out  2  next-PC source: 00=ALU, 01=branch target reg, 10=rs (jr), 11=jump addr
state  out  3  IF=0, ID=1, EXE=2, MEM=3, WB=4, ERR=5
retired  out  CNT_W  completed-instruction count
err  out  1  watchdog fired (sticky)
illegal  out  1  one-cycle pulse: undecodable instruction in ID

Behaviour:
- Supported instructions:
  - R-type: add, sub, and, or, xor, sll, srl, sra, jr.
  - I/J-type: addi, andi, ori, xori, lui, lw, sw, beq, bne, j, jal.
- Only state, retired, err and the watchdog counter are registered. All other outputs are combinational from state/op/func/z/mem_ready and default to 0.
- Reset (async, resetn=0): state=IF, retired=0, err=0, wait counter=0; wpc, wir, wmem and wreg are forced to 0 while resetn=0. Reset mid-instruction abandons the instruction.
- IF:
  - Drives iord=0, alusrca=0, alusrcb=01, aluc=0000, pcsource=00.
  - wpc=wir=1 only in a cycle with mem_ready=1 (always when MEM_HS=0), then go to ID. Otherwise stay in IF and increment the wait counter.
- ID:
  - Drives alusrca=0, alusrcb=11, sext=1 (branch target latched by datapath).
  - j: wpc=1, pcsource=11, go to IF.
  - jal: wpc=1, pcsource=11, wreg=1, jal=1, go to IF.
  - jr: wpc=1, pcsource=10, go to IF.
  - Undecodable op/func: illegal=1, no writes, go to IF. This counts as retired.
  - All other instructions go to EXE.
- EXE:
  - aluc as listed. alusrca=1. shift=1 for sll/srl/sra. alusrcb=10 for I-type ALU ops and lw/sw, else 00.
  - sext=1 for addi/lw/sw/beq/bne. andi/ori/xori/lui zero-extend.
  - beq/bne: aluc=sub, pcsource=01, wpc=(beq&z)|(bne&~z), go to IF.
  - lw/sw go to MEM; all others go to WB.
- MEM:
  - Drives iord=1.
  - sw: wmem=1 held each cycle until mem_ready=1, then go to IF.
  - lw: wait for mem_ready=1, then go to WB.
- WB:
  - wreg=1. regrt=1 for I-type. m2reg=1 for lw.
  - Go to IF.
- Watchdog (MEM_HS=1):
  - The counter clears on every state change.
  - It increments each cycle spent in IF or MEM with mem_ready=0.
  - When the counter equals WAIT_MAX-1 and mem_ready=0, the next state is ERR.
  - mem_ready=1 on the final allowed cycle wins, and no error is raised.
- ERR: err=1, all enables 0, and the FSM stays in ERR until reset.
- retired:
  - Increments by 1 on every transition into IF from ID, EXE, MEM or WB.
  - It does not increment on IF→IF or on entry to ERR.
  - Wraps modulo 2^CNT_W.
- z and mem_ready are sampled only in the states listed above; in every other state they are ignored.

Test Plan:
- MEM_HS=1, mem_ready tied 1, add (op 000000, func 100000) → states 0,1,2,4,0; wreg=1 with regrt=0 in WB; retired 0→1.
- lw with mem_ready low 3 cycles in MEM → MEM held 4 cycles with iord=1; then WB with wreg=1, m2reg=1, regrt=1; total 8 cycles.
- beq with z=1 → wpc=1, pcsource=01 in EXE; with z=0 → wpc=0; bne inverted. Each takes 3 cycles.
- WAIT_MAX=4, mem_ready held 0 in IF → state=ERR after 4 cycles, err=1 sticky, retired unchanged. mem_ready=1 on 4th cycle → ID, no err.
- op 111111 → illegal pulses 1 cycle in ID, no write enables, back to IF, retired+1. CNT_W=2 after 4 instructions → retired=0.
- resetn pulled low during MEM of sw → wmem drops immediately, state=0, retired=0; MEM_HS=0 → lw completes in 5 cycles regardless of mem_ready.
